pc_sequencer: RTL

Program-counter sequencer for the single-cycle core. Owns the PC register and the run/halt handshake with the testbench. Resolves taken branches via the branch-target lookup table instantiated alongside it in the top level. Each cycle it selects hold, PC+1, absolute LUT target or PC-relative LUT offset, and counts retired instructions.

---
 rtl/core_pkg.sv | 17 +
 rtl/pc_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/core_pkg.sv
// Shared constants and state type for the program-counter sequencer.
// Pure declarations; no logic or latency.
// No flow control; consumers import the widths they need.
package core_pkg;

    localparam int PC_W  = 10;   // program counter / LUT target width
    localparam int LA_W  = 5;    // LUT pointer width
    localparam int CNT_W = 16;   // retired-instruction counter width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } pcseq_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the PC, run/halt handshake and retired-instruction count.
// Latency: one cycle for PC, Done, Busy and InstrCnt; LutAddr is a combinational pass-through.
// Backpressure: Stall freezes PC and count; Halt is deferred until Stall drops.
module pc_sequencer
    import core_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             BranchEn,
    input  logic             Taken,
    input  logic             BranchAbs,
    input  logic [LA_W-1:0]  LutSel,
    input  logic [PC_W-1:0]  LutTarget,
    input  logic             Stall,
    output logic [LA_W-1:0]  LutAddr,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Done,
    output logic             Busy,
    output logic [CNT_W-1:0] InstrCnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    pcseq_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q,    pc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;
    logic             busy_q,  busy_d;
    logic [CNT_W-1:0] cnt_inc;

    // The LUT sits beside the sequencer, so the target must be usable in the same cycle.
    assign LutAddr  = LutSel;
    assign ProgCtr  = pc_q;
    assign Done     = done_q;
    assign Busy     = busy_q;
    assign InstrCnt = cnt_q;

    // Next-state, next-PC mux and saturating retire counter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                pc_d  = '0;
                cnt_d = '0;
                if (Start) state_d = ARMED;
            end
            ARMED: begin
                pc_d  = '0;
                cnt_d = '0;
                if (!Start) state_d = RUN;
            end
            RUN: begin
                if (Start) begin
                    // A restart abandons the current program outright.
                    state_d = ARMED;
                    pc_d    = '0;
                    cnt_d   = '0;
                end else if (Stall) begin
                    // Instruction still in progress: hold everything.
                    state_d = RUN;
                end else if (Halt) begin
                    // PC stays on the DONE instruction; it still counts as retired.
                    state_d = HALTED;
                    cnt_d   = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                    if (BranchEn && Taken) begin
                        // Relative add wraps naturally at PC_W bits, which sign-extends the offset.
                        pc_d = BranchAbs ? LutTarget : pc_q + LutTarget;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            HALTED: begin
                if (Start) begin
                    state_d = ARMED;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase

        // Status flags follow the state they are about to report, so they update on the same edge.
        done_d = (state_d == HALTED);
        busy_d = (state_d == RUN);
    end

    // State, PC, count and status registers; reset is asynchronous and discards any run.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

endmodule
